// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: MemOp codes, FSM state
// encoding, access-size decode and default widths.
package mem_stage_lsu_pkg;

    localparam int LSU_DATA_WIDTH     = 32;
    localparam int LSU_REG_ADDR_WIDTH = 5;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SIZE_B,
        SIZE_H,
        SIZE_W
    } access_size_t;

    // Unsigned variants only exist for loads; any unknown code is a word access.
    function automatic access_size_t access_size(input logic [2:0] mem_op, input logic is_store);
        access_size_t size;
        size = SIZE_W;
        if (mem_op == MEMOP_B || (!is_store && mem_op == MEMOP_BU))
            size = SIZE_B;
        else if (mem_op == MEMOP_H || (!is_store && mem_op == MEMOP_HU))
            size = SIZE_H;
        return size;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: byte enables, store-lane replication and load
// extraction with sign/zero extension, all derived from (MemOp, addr[1:0]).
module lsu_lane_align
    import mem_stage_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = LSU_DATA_WIDTH
) (
    input  logic [2:0]            mem_op,
    input  logic                  is_store,
    input  logic [1:0]            addr_lo,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] load_word,
    output logic [3:0]            be,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data
);

    access_size_t          size;
    logic [1:0]            lane;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  is_unsigned;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        size        = access_size(mem_op, is_store);
        is_unsigned = mem_op[2];
        lane        = 2'b00;
        be          = 4'b1111;
        wdata       = store_data;
        // Misaligned halves fall back to the half picked by addr[1]; words to lane 0.
        case (size)
            SIZE_B: begin
                lane  = addr_lo;
                be    = 4'b0001 << addr_lo;
                wdata = {(DATA_WIDTH/8){store_data[7:0]}};
            end
            SIZE_H: begin
                lane  = {addr_lo[1], 1'b0};
                be    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {(DATA_WIDTH/16){store_data[15:0]}};
            end
            default: ;
        endcase
        shifted   = load_word >> {lane, 3'b000};
        load_data = shifted;
        case (size)
            SIZE_B: load_data = is_unsigned ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
                                            : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            SIZE_H: load_data = is_unsigned ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
                                            : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: request/acknowledge bus FSM, stall generation and
// control pass-through. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = LSU_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = LSU_REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     I_result,
    input  logic [DATA_WIDTH-1:0]     I_regReadData2,
    input  logic                      I_MemRead,
    input  logic                      I_MemWrite,
    input  logic [2:0]                I_MemOp,
    input  logic [REG_ADDR_WIDTH-1:0] I_writeRegister,
    input  logic                      I_RegWrite,
    input  logic                      I_MemtoReg,
    output logic [DATA_WIDTH-1:0]     O_daddr,
    output logic [DATA_WIDTH-1:0]     O_dwdata,
    output logic [3:0]                O_dbe,
    output logic                      O_dwe,
    output logic                      O_dreq,
    input  logic                      I_dack,
    input  logic [DATA_WIDTH-1:0]     I_drdata,
    output logic [DATA_WIDTH-1:0]     O_loadData,
    output logic [REG_ADDR_WIDTH-1:0] O_writeRegister,
    output logic                      O_RegWrite,
    output logic                      O_MemtoReg,
    output logic                      O_stall
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic                      O_misalign
`endif
);

    lsu_state_t            state, state_next;
    logic                  access;
    logic                  fault;
    logic [2:0]            op_q;
    logic [1:0]            lo_q;
    logic                  in_idle;
    logic [3:0]            align_be;
    logic [DATA_WIDTH-1:0] align_wdata;
    logic [DATA_WIDTH-1:0] align_load;

    assign access  = I_MemRead | I_MemWrite;
    assign in_idle = (state == LSU_IDLE);

    // One aligner serves both directions: live inputs while idle, the latched access afterwards.
    lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .mem_op     (in_idle ? I_MemOp : op_q),
        .is_store   (in_idle ? !I_MemRead : O_dwe),
        .addr_lo    (in_idle ? I_result[1:0] : lo_q),
        .store_data (I_regReadData2),
        .load_word  (I_drdata),
        .be         (align_be),
        .wdata      (align_wdata),
        .load_data  (align_load)
    );

    always_comb begin
        state_next = state;
        case (state)
            LSU_IDLE: if (access) state_next = fault ? LSU_DONE : LSU_REQ;
            LSU_REQ:  if (I_dack) state_next = LSU_DONE;
            LSU_DONE: state_next = LSU_IDLE;
            default:  state_next = LSU_IDLE;
        endcase
    end

    assign O_dreq  = (state == LSU_REQ);
    assign O_stall = access && (state != LSU_DONE);

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: bus and result registers are reset so the bus sees a known-quiet interface after reset.
        if (!rst) begin
            state      <= LSU_IDLE;
            O_daddr    <= '0;
            O_dwdata   <= '0;
            O_dbe      <= '0;
            O_dwe      <= 1'b0;
            O_loadData <= '0;
            op_q       <= '0;
            lo_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state <= state_next;
            if (in_idle && access && !fault) begin
                O_daddr  <= {I_result[DATA_WIDTH-1:2], 2'b00};
                O_dwdata <= align_wdata;
                O_dbe    <= align_be;
                O_dwe    <= !I_MemRead;
                op_q     <= I_MemOp;
                lo_q     <= I_result[1:0];
            end
            if (state == LSU_REQ && I_dack && !O_dwe)
                O_loadData <= align_load;
        end
    end

    assign O_writeRegister = I_writeRegister;
    assign O_MemtoReg      = I_MemtoReg;

`ifdef LSU_MISALIGN_TRAP_EN
    access_size_t req_size;
    logic         misalign_q;

    assign req_size = access_size(I_MemOp, !I_MemRead);
    assign fault    = access && ((req_size == SIZE_H && I_result[0]) ||
                                 (req_size == SIZE_W && I_result[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) misalign_q <= 1'b0;
        else      misalign_q <= in_idle && fault;
    end

    assign O_misalign = misalign_q;
    // The trapped instruction must not write back while it sits in EX/MEM.
    assign O_RegWrite = I_RegWrite && !(fault || misalign_q);
`else
    assign fault      = 1'b0;
    assign O_RegWrite = I_RegWrite;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu; covers the misalign trap when
// LSU_MISALIGN_TRAP_EN is defined, truncation behaviour otherwise.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] I_result, I_regReadData2, I_drdata;
    logic        I_MemRead, I_MemWrite, I_RegWrite, I_MemtoReg, I_dack;
    logic [2:0]  I_MemOp;
    logic [4:0]  I_writeRegister;
    logic [31:0] O_daddr, O_dwdata, O_loadData;
    logic [3:0]  O_dbe;
    logic        O_dwe, O_dreq, O_RegWrite, O_MemtoReg, O_stall;
    logic [4:0]  O_writeRegister;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        O_misalign;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk             (clk),
        .rst             (rst),
        .I_result        (I_result),
        .I_regReadData2  (I_regReadData2),
        .I_MemRead       (I_MemRead),
        .I_MemWrite      (I_MemWrite),
        .I_MemOp         (I_MemOp),
        .I_writeRegister (I_writeRegister),
        .I_RegWrite      (I_RegWrite),
        .I_MemtoReg      (I_MemtoReg),
        .O_daddr         (O_daddr),
        .O_dwdata        (O_dwdata),
        .O_dbe           (O_dbe),
        .O_dwe           (O_dwe),
        .O_dreq          (O_dreq),
        .I_dack          (I_dack),
        .I_drdata        (I_drdata),
        .O_loadData      (O_loadData),
        .O_writeRegister (O_writeRegister),
        .O_RegWrite      (O_RegWrite),
        .O_MemtoReg      (O_MemtoReg),
        .O_stall         (O_stall)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .O_misalign      (O_misalign)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_access();
        I_MemRead  = 1'b0;
        I_MemWrite = 1'b0;
        I_MemOp    = 3'b000;
        I_result   = 32'h0;
    endtask

    // One full transaction: access in cycle 0, ack in cycle 1+k, DONE in cycle 2+k.
    task automatic run_access(input string tag, input logic rd, input logic [2:0] op,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int k,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_load);
        I_result       = addr;
        I_regReadData2 = wdata;
        I_MemRead      = rd;
        I_MemWrite     = !rd;
        I_MemOp        = op;
        #1;
        check({tag, " c0 stall"}, O_stall, 1'b1);
        check({tag, " c0 dreq"}, O_dreq, 1'b0);
        tick();
        check({tag, " c1 dreq"}, O_dreq, 1'b1);
        check({tag, " c1 daddr"}, O_daddr, exp_addr);
        check({tag, " c1 dbe"}, O_dbe, exp_be);
        check({tag, " c1 dwe"}, O_dwe, !rd);
        if (!rd) check({tag, " c1 dwdata"}, O_dwdata, exp_wdata);
        for (int i = 0; i < k; i++) begin
            check({tag, " wait stall"}, O_stall, 1'b1);
            tick();
            check({tag, " wait dreq"}, O_dreq, 1'b1);
            check({tag, " wait daddr"}, O_daddr, exp_addr);
            check({tag, " wait dbe"}, O_dbe, exp_be);
            check({tag, " wait dwe"}, O_dwe, !rd);
        end
        I_dack   = 1'b1;
        I_drdata = rdata;
        #1;
        check({tag, " ack stall"}, O_stall, 1'b1);
        tick();
        I_dack   = 1'b0;
        I_drdata = 32'hA5A5_A5A5;
        #1;
        check({tag, " done stall"}, O_stall, 1'b0);
        check({tag, " done dreq"}, O_dreq, 1'b0);
        check({tag, " loadData"}, O_loadData, exp_load);
        clear_access();
        tick();
        check({tag, " idle stall"}, O_stall, 1'b0);
        check({tag, " idle dreq"}, O_dreq, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        I_result        = 32'h0;
        I_regReadData2  = 32'h0;
        I_drdata        = 32'h0;
        I_MemRead       = 1'b0;
        I_MemWrite      = 1'b0;
        I_MemOp         = 3'b000;
        I_writeRegister = 5'd9;
        I_RegWrite      = 1'b1;
        I_MemtoReg      = 1'b1;
        I_dack          = 1'b0;
        #1 rst = 1'b0;
        #2;
        check("rst dreq", O_dreq, 1'b0);
        check("rst dwe", O_dwe, 1'b0);
        check("rst dbe", O_dbe, 4'b0000);
        check("rst daddr", O_daddr, 32'h0);
        check("rst dwdata", O_dwdata, 32'h0);
        check("rst loadData", O_loadData, 32'h0);
        check("rst pass wreg", O_writeRegister, 5'd9);
        check("rst pass regwrite", O_RegWrite, 1'b1);
        check("rst pass memtoreg", O_MemtoReg, 1'b1);
`ifdef LSU_MISALIGN_TRAP_EN
        check("rst misalign", O_misalign, 1'b0);
`endif
        tick();
        rst = 1'b1;
        tick();

        I_writeRegister = 5'd22;
        I_RegWrite      = 1'b0;
        I_MemtoReg      = 1'b0;
        #1;
        check("pass wreg", O_writeRegister, 5'd22);
        check("pass regwrite", O_RegWrite, 1'b0);
        check("pass memtoreg", O_MemtoReg, 1'b0);
        check("no access stall", O_stall, 1'b0);
        I_RegWrite = 1'b1;
        tick();

        run_access("SW",  1'b0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1,
                   32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        run_access("LB",  1'b1, 3'b000, 32'h0000_0203, 32'h0, 32'h8011_2233, 0,
                   32'h0000_0200, 4'b1000, 32'h0, 32'hFFFF_FF80);
        run_access("LBU", 1'b1, 3'b100, 32'h0000_0203, 32'h0, 32'h8011_2233, 0,
                   32'h0000_0200, 4'b1000, 32'h0, 32'h0000_0080);
        run_access("LH",  1'b1, 3'b001, 32'h0000_0302, 32'h0, 32'h7FFE_0000, 0,
                   32'h0000_0300, 4'b1100, 32'h0, 32'h0000_7FFE);
        run_access("SH",  1'b0, 3'b001, 32'h0000_0302, 32'h0000_ABCD, 32'h0, 0,
                   32'h0000_0300, 4'b1100, 32'hABCD_ABCD, 32'h0000_7FFE);
        run_access("SB",  1'b0, 3'b000, 32'h0000_0101, 32'h1234_565A, 32'h0, 2,
                   32'h0000_0100, 4'b0010, 32'h5A5A_5A5A, 32'h0000_7FFE);
        run_access("LW wait10", 1'b1, 3'b010, 32'h0000_0500, 32'h0, 32'hCAFE_F00D, 10,
                   32'h0000_0500, 4'b1111, 32'h0, 32'hCAFE_F00D);

`ifdef LSU_MISALIGN_TRAP_EN
        I_result   = 32'h0000_0101;
        I_MemRead  = 1'b1;
        I_MemOp    = 3'b010;
        I_RegWrite = 1'b1;
        #1;
        check("trap c0 stall", O_stall, 1'b1);
        check("trap c0 regwrite", O_RegWrite, 1'b0);
        check("trap c0 misalign", O_misalign, 1'b0);
        check("trap c0 dreq", O_dreq, 1'b0);
        tick();
        check("trap done misalign", O_misalign, 1'b1);
        check("trap done dreq", O_dreq, 1'b0);
        check("trap done stall", O_stall, 1'b0);
        check("trap done regwrite", O_RegWrite, 1'b0);
        clear_access();
        tick();
        check("trap idle misalign", O_misalign, 1'b0);
        check("trap idle dreq", O_dreq, 1'b0);
        check("trap idle regwrite", O_RegWrite, 1'b1);
`else
        run_access("LW mis", 1'b1, 3'b010, 32'h0000_0102, 32'h0, 32'h1122_3344, 0,
                   32'h0000_0100, 4'b1111, 32'h0, 32'h1122_3344);
        run_access("LH mis", 1'b1, 3'b001, 32'h0000_0303, 32'h0, 32'h8001_1234, 0,
                   32'h0000_0300, 4'b1100, 32'h0, 32'hFFFF_8001);
`endif

        I_result  = 32'h0000_0400;
        I_MemRead = 1'b1;
        I_MemOp   = 3'b010;
        tick();
        check("rstmid req dreq", O_dreq, 1'b1);
        rst = 1'b0;
        #1;
        check("rstmid dreq", O_dreq, 1'b0);
        check("rstmid daddr", O_daddr, 32'h0);
        check("rstmid loadData", O_loadData, 32'h0);
        clear_access();
        tick();
        rst      = 1'b1;
        I_dack   = 1'b1;
        I_drdata = 32'hFFFF_FFFF;
        #1;
        check("late ack dreq", O_dreq, 1'b0);
        tick();
        check("late ack ignored dreq", O_dreq, 1'b0);
        check("late ack ignored load", O_loadData, 32'h0);
        check("late ack stall", O_stall, 1'b0);
        I_dack = 1'b0;
        tick();

        run_access("LHU", 1'b1, 3'b101, 32'h0000_0002, 32'h0, 32'hF00D_0000, 0,
                   32'h0000_0000, 4'b1100, 32'h0, 32'h0000_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
